// File: rtl/amm_seq_master.sv
// Avalon-MM sequence master: single read/write, multi-word fill and readback check.
// Define AMM_SEQ_MASTER_ERRLOG_EN to add first-mismatch address/data capture.
module amm_seq_master #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int LEN_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_start,
    input  logic [1:0]              cmd_mode,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0]    cmd_data,
    input  logic [LEN_W-1:0]        cmd_len,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_count,
    output logic [31:0]             display_data,
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
    output logic [ADDRESSWIDTH-1:0] first_err_addr,
    output logic [DATAWIDTH-1:0]    first_err_data,
`endif
    output logic [ADDRESSWIDTH-1:0] avm_address,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [DATAWIDTH-1:0]    avm_writedata,
    output logic [DATAWIDTH/8-1:0]  avm_byteenable,
    input  logic [DATAWIDTH-1:0]    avm_readdata,
    input  logic                    avm_readdatavalid,
    input  logic                    avm_waitrequest
);

    localparam logic [1:0] MODE_WRITE = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_CHECK = 2'b11;
    localparam logic [ADDRESSWIDTH-1:0] STRIDE = ADDRESSWIDTH'(DATAWIDTH / 8);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_DONE} state_t;

    state_t                  state;
    logic                    start_q;
    logic                    start_prev;
    logic [1:0]              mode;
    logic [ADDRESSWIDTH-1:0] base;
    logic [DATAWIDTH-1:0]    seed;
    logic [LEN_W-1:0]        len;
    logic [LEN_W-1:0]        idx;

    function automatic logic [ADDRESSWIDTH-1:0] word_addr(input logic [ADDRESSWIDTH-1:0] b,
                                                          input logic [LEN_W-1:0]        i);
        return b + ADDRESSWIDTH'(i) * STRIDE;
    endfunction

    logic                 launch;
    logic [LEN_W-1:0]     idx_next;
    logic                 last_word;
    logic [DATAWIDTH-1:0] expect_data;
    logic                 mismatch;
    logic [15:0]          err_next;
    logic [31:0]          seq_status;
    logic [31:0]          check_display;

    assign launch      = start_q & ~start_prev;
    assign idx_next    = idx + LEN_W'(1);
    assign last_word   = (idx_next == len);
    assign expect_data = seed + DATAWIDTH'(idx);
    assign mismatch    = (mode == MODE_CHECK) && (avm_readdata != expect_data);
    assign err_next    = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    assign seq_status  = {err_next, 16'(idx_next)};

`ifdef AMM_SEQ_MASTER_ERRLOG_EN
    // err_count is cleared at check launch, so zero here means no mismatch logged yet.
    logic                 first_hit;
    logic [DATAWIDTH-1:0] log_data_next;
    assign first_hit     = mismatch && (err_count == 16'd0);
    assign log_data_next = first_hit ? avm_readdata : first_err_data;
    assign check_display = (mode == MODE_CHECK && err_next != 16'd0) ? 32'(log_data_next) : seq_status;
`else
    assign check_display = seq_status;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            start_q        <= 1'b0;
            start_prev     <= 1'b0;
            mode           <= '0;
            base           <= '0;
            seed           <= '0;
            len            <= '0;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            display_data   <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
            first_err_addr <= '0;
            first_err_data <= '0;
`endif
        end else begin
            // NOTE: non-blocking everywhere, so every branch reads the pre-edge register values.
            start_q    <= cmd_start;
            start_prev <= start_q;
            done       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        mode <= cmd_mode;
                        base <= cmd_addr;
                        seed <= cmd_data;
                        idx  <= '0;
                        len  <= cmd_mode[1] ? cmd_len : LEN_W'(1);
                        if (cmd_mode[1]) err_count <= '0;
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
                        if (cmd_mode == MODE_CHECK) begin
                            first_err_addr <= '0;
                            first_err_data <= '0;
                        end
`endif
                        if (cmd_mode[1] && cmd_len == '0) begin
                            done         <= 1'b1;
                            display_data <= '0;
                            state        <= S_DONE;
                        end else begin
                            busy           <= 1'b1;
                            avm_address    <= cmd_addr;
                            avm_byteenable <= '1;
                            if (cmd_mode[0]) begin
                                avm_read <= 1'b1;
                                state    <= S_RD_REQ;
                            end else begin
                                avm_write     <= 1'b1;
                                avm_writedata <= cmd_data;
                                state         <= S_WR;
                            end
                        end
                    end
                end

                S_WR: begin
                    if (!avm_waitrequest) begin
                        idx <= idx_next;
                        if (last_word) begin
                            avm_write      <= 1'b0;
                            avm_byteenable <= '0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            display_data   <= (mode == MODE_WRITE) ? 32'(avm_writedata)
                                                                   : {err_count, 16'(idx_next)};
                            state          <= S_DONE;
                        end else begin
                            avm_address   <= word_addr(base, idx_next);
                            avm_writedata <= seed + DATAWIDTH'(idx_next);
                        end
                    end
                end

                S_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read       <= 1'b0;
                        avm_byteenable <= '0;
                        state          <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        idx       <= idx_next;
                        err_count <= err_next;
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
                        if (first_hit) begin
                            first_err_addr <= word_addr(base, idx);
                            first_err_data <= avm_readdata;
                        end
`endif
                        if (last_word) begin
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            display_data <= (mode == MODE_READ) ? 32'(avm_readdata) : check_display;
                            state        <= S_DONE;
                        end else begin
                            avm_read       <= 1'b1;
                            avm_byteenable <= '1;
                            avm_address    <= word_addr(base, idx_next);
                            state          <= S_RD_REQ;
                        end
                    end
                end

                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amm_seq_master.sv
// Directed bench for amm_seq_master: a slave/memory model drives the bus, a per-cycle
// monitor compares bus traffic and completion status against a word-level command model.
module tb_amm_seq_master;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_start = 1'b0;
    logic [1:0]    cmd_mode = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          busy, done;
    logic [15:0]   err_count;
    logic [31:0]   display_data;
    logic [AW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          avm_waitrequest = 1'b0;
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;
`endif

    amm_seq_master #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_len(cmd_len),
        .busy(busy), .done(done), .err_count(err_count), .display_data(display_data),
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
`endif
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave memory and the command model's expectations.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] exp_wr_addr [$];
    logic [DW-1:0] exp_wr_data [$];
    logic [AW-1:0] exp_rd_addr [$];
    logic [15:0]   m_err = '0;
    logic [31:0]   m_display = '0;
    logic [AW-1:0] m_first_addr = '0;
    logic [DW-1:0] m_first_data = '0;
    int            exp_len = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    int          ws = 0;
    int          rd_lat = 1;
    int          stall_cnt = 0;
    int          rd_timer = 0;
    bit          rd_pending = 0;
    logic [AW-1:0] rd_addr = '0;
    bit          stray_valid = 0;
    int          cyc = 0;
    int          last_evt = 0;
    int          done_seen = 0;
    int          wr_cycles = 0;
    int          rd_accepts = 0;
    bit          prev_stalled = 0;
    bit          prev_done = 0;
    logic [61:0] prev_req = '0;

    // Slave responses and output monitor; decides this cycle's waitrequest/readdatavalid.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
            stall_cnt    = 0;
            rd_pending   = 0;
            prev_stalled = 0;
            prev_done    = 0;
        end else begin
            avm_readdatavalid = 1'b0;
            if (rd_pending) begin
                rd_timer--;
                if (rd_timer == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem_rd(rd_addr);
                    rd_pending        = 0;
                    last_evt          = cyc;
                end
            end else if (stray_valid) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'h5A5A_5A5A;
                stray_valid       = 0;
            end

            if (avm_write || avm_read) begin
                check("byteenable_active", 64'(avm_byteenable), 64'hF);
                check("busy_during_request", 64'(busy), 64'd1);
                check("read_write_exclusive", 64'(avm_read & avm_write), 64'd0);
                if (prev_stalled)
                    check("request_stable_in_wait",
                          64'({avm_address, avm_writedata, avm_read, avm_write}), 64'(prev_req));
                if (avm_write) wr_cycles++;
                if (stall_cnt < ws) begin
                    avm_waitrequest = 1'b1;
                    stall_cnt++;
                    prev_stalled = 1;
                    prev_req = {avm_address, avm_writedata, avm_read, avm_write};
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt    = 0;
                    prev_stalled = 0;
                    last_evt     = cyc;
                    if (avm_write) begin
                        check("write_expected", 64'(exp_wr_addr.size() != 0), 64'd1);
                        if (exp_wr_addr.size() != 0) begin
                            check("write_addr", 64'(avm_address), 64'(exp_wr_addr.pop_front()));
                            check("write_data", 64'(avm_writedata), 64'(exp_wr_data.pop_front()));
                        end
                        mem[avm_address] = avm_writedata;
                    end else begin
                        rd_accepts++;
                        check("read_expected", 64'(exp_rd_addr.size() != 0), 64'd1);
                        if (exp_rd_addr.size() != 0)
                            check("read_addr", 64'(avm_address), 64'(exp_rd_addr.pop_front()));
                        rd_pending = 1;
                        rd_timer   = rd_lat;
                        rd_addr    = avm_address;
                    end
                end
            end else begin
                check("byteenable_idle", 64'(avm_byteenable), 64'd0);
                avm_waitrequest = 1'b0;
                stall_cnt    = 0;
                prev_stalled = 0;
            end

            if (done) begin
                done_seen++;
                check("done_busy_low", 64'(busy), 64'd0);
                check("done_display", 64'(display_data), 64'(m_display));
                check("done_err_count", 64'(err_count), 64'(m_err));
                check("done_all_words_moved", 64'(exp_wr_addr.size() + exp_rd_addr.size()), 64'd0);
                check("done_single_pulse", 64'(prev_done), 64'd0);
                if (exp_len > 0) check("done_latency", 64'(cyc - last_evt), 64'd1);
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
                check("done_first_err_addr", 64'(first_err_addr), 64'(m_first_addr));
                check("done_first_err_data", 64'(first_err_data), 64'(m_first_data));
`endif
            end
            prev_done = done;
        end
    end

    // Word-level model of one command, then launch and wait for completion.
    task automatic run_cmd(input logic [1:0] mode, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [LW-1:0] len,
                           input int wsv, input int lat, input int toggle_at);
        int n, errs, t, base_done;
        logic [AW-1:0] a;
        logic [DW-1:0] d, fdata;
        logic [AW-1:0] faddr;
        bit got_done;
        n = mode[1] ? int'(len) : 1;
        errs = 0; fdata = '0; faddr = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + AW'(i * 4);
            d = data + DW'(i);
            if (!mode[0]) begin
                exp_wr_addr.push_back(a);
                exp_wr_data.push_back(d);
            end else begin
                exp_rd_addr.push_back(a);
            end
            if (mode == 2'b11 && mem_rd(a) != d) begin
                if (errs == 0) begin
                    faddr = a;
                    fdata = mem_rd(a);
                end
                errs++;
            end
        end
        if (mode[1]) m_err = (errs > 65535) ? 16'hFFFF : 16'(errs);
        case (mode)
            2'b00:   m_display = data;
            2'b01:   m_display = mem_rd(addr);
            default: m_display = {m_err, 16'(n)};
        endcase
        if (mode == 2'b11) begin
            m_first_addr = faddr;
            m_first_data = fdata;
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
            if (m_err != 16'd0) m_display = fdata;
`endif
        end
        exp_len = n;

        @(negedge clk);
        base_done = done_seen;
        ws = wsv;
        rd_lat = lat;
        cmd_mode = mode; cmd_addr = addr; cmd_data = data; cmd_len = len;
        cmd_start = 1'b1;
        // Rising edge is registered, then the state: the response is seen after the second edge.
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(avm_write || avm_read || done) && t < 10);
        check("launch_latency", 64'(t), 64'd2);
        got_done = done;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            if (toggle_at != 0 && c == toggle_at) cmd_start = 1'b0;
            if (toggle_at != 0 && c == toggle_at + 1) cmd_start = 1'b1;
            @(negedge clk);
            got_done = done;
        end
        check("cmd_completed", 64'(got_done), 64'd1);
        if (!got_done) begin
            exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
        end
        cmd_start = 1'b0;
        repeat (8) @(negedge clk);
        check("one_done_per_cmd", 64'(done_seen - base_done), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
        check({tag, "_display"}, 64'(display_data), 64'd0);
        check({tag, "_bus_ctrl"}, 64'({avm_read, avm_write, avm_byteenable}), 64'd0);
        check({tag, "_bus_data"}, 64'({avm_address, avm_writedata}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single write held through three waitrequest cycles.
        wr_cycles = 0;
        run_cmd(2'b00, 28'h100, 32'hDEAD_BEEF, 16'd0, 3, 1, 0);
        check("t1_write_cycles", 64'(wr_cycles), 64'd4);
        check("t1_display", 64'(display_data), 64'hDEAD_BEEF);
        check("t1_mem", 64'(mem_rd(28'h100)), 64'hDEAD_BEEF);

        // Single read, data returned five cycles after acceptance.
        rd_accepts = 0;
        run_cmd(2'b01, 28'h100, 32'h0, 16'd0, 0, 5, 0);
        check("t2_read_count", 64'(rd_accepts), 64'd1);
        check("t2_display", 64'(display_data), 64'hDEAD_BEEF);

        // Fill wrapping both address and pattern.
        run_cmd(2'b10, 28'hFFF_FFFC, 32'hFFFF_FFFF, 16'd3, 1, 1, 0);
        check("t3_mem0", 64'(mem_rd(28'hFFF_FFFC)), 64'hFFFF_FFFF);
        check("t3_mem1", 64'(mem_rd(28'h000_0000)), 64'h0);
        check("t3_mem2", 64'(mem_rd(28'h000_0004)), 64'h1);
        check("t3_display", 64'(display_data), 64'h0000_0003);

        // Fill seed 0x10, corrupt word 2, then check four words.
        run_cmd(2'b10, 28'h0, 32'h10, 16'd4, 0, 1, 0);
        mem[28'h8] = 32'hBAD0_BAD0;
        run_cmd(2'b11, 28'h0, 32'h10, 16'd4, 2, 3, 0);
        check("t4_err_count", 64'(err_count), 64'd1);
`ifdef AMM_SEQ_MASTER_ERRLOG_EN
        check("t4_first_err_addr", 64'(first_err_addr), 64'h8);
        check("t4_display", 64'(display_data), 64'hBAD0_BAD0);
`else
        check("t4_display", 64'(display_data), 64'h0001_0004);
`endif

        // A readdatavalid pulse while idle changes nothing.
        stray_valid = 1;
        repeat (4) @(negedge clk);
        check("stray_valid_err", 64'(err_count), 64'(m_err));
        check("stray_valid_display", 64'(display_data), 64'(m_display));

        // Check of zero words: done without bus traffic, err_count cleared.
        rd_accepts = 0;
        run_cmd(2'b11, 28'h0, 32'h10, 16'd0, 0, 1, 0);
        check("t5_no_reads", 64'(rd_accepts), 64'd0);
        check("t5_err_count", 64'(err_count), 64'd0);
        check("t5_display", 64'(display_data), 64'd0);

        // Start re-toggled mid-command must not queue a second fill.
        run_cmd(2'b10, 28'h200, 32'hA0, 16'd4, 2, 1, 3);
        run_cmd(2'b11, 28'h200, 32'hA0, 16'd4, 1, 2, 0);
        check("t6_clean_check", 64'(display_data), 64'h0000_0004);

        // Reset in the middle of a fill.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            exp_wr_addr.push_back(28'h300 + AW'(i * 4));
            exp_wr_data.push_back(32'h55 + DW'(i));
        end
        ws = 1;
        cmd_mode = 2'b10; cmd_addr = 28'h300; cmd_data = 32'h55; cmd_len = 16'd8;
        cmd_start = 1'b1;
        repeat (7) @(negedge clk);
        check("mid_fill_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        cmd_start = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
        m_err = '0; m_display = '0; m_first_addr = '0; m_first_data = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_cmd(2'b10, 28'h40, 32'h7, 16'd2, 0, 1, 0);
        check("post_reset_mem", 64'(mem_rd(28'h44)), 64'h8);
        check("post_reset_display", 64'(display_data), 64'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
